// File: rtl/sccb_pkg.sv
// Shared constants and width helpers for the SCCB line conditioner.
package sccb_pkg;

    localparam int SIO_C_IDX = 0;
    localparam int SIO_D_IDX = 1;

    localparam logic SCCB_IDLE_LEVEL = 1'b1;

    localparam int FILTER_LEN_DEF   = 4;
    localparam int STUCK_CYCLES_DEF = 65535;

    // Width of a counter that must hold 0..n-1 (never narrower than 1 bit).
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int FILT_CNT_W_DEF  = cnt_w(FILTER_LEN_DEF);
    localparam int STUCK_CNT_W_DEF = cnt_w(STUCK_CYCLES_DEF);

endpackage

// File: rtl/sccb_line_conditioner_if.sv
// GPIO controller <-> line conditioner <-> pad bundle.
interface sccb_line_conditioner_if;

    logic [1:0] GPIO_OUT;
    logic [1:0] GPIO_OE;
    logic [1:0] GPIO_IN;
    logic [1:0] PAD_I;
    logic [1:0] PAD_OE;
    logic [1:0] EDGE_RISE;
    logic [1:0] EDGE_FALL;
    logic       START_DET;
    logic       STOP_DET;
    logic [1:0] STUCK_LOW;
    logic       STUCK_CLR;

    modport master (
        output GPIO_OUT, GPIO_OE, PAD_I, STUCK_CLR,
        input  GPIO_IN, PAD_OE, EDGE_RISE, EDGE_FALL,
        input  START_DET, STOP_DET, STUCK_LOW
    );

    modport slave (
        input  GPIO_OUT, GPIO_OE, PAD_I, STUCK_CLR,
        output GPIO_IN, PAD_OE, EDGE_RISE, EDGE_FALL,
        output START_DET, STOP_DET, STUCK_LOW
    );

endinterface

// File: rtl/sccb_glitch_filter.sv
// One SCCB line: 2-flop synchroniser, run-length glitch filter and
// edge pulses that coincide with the filtered level change.
module sccb_glitch_filter
    import sccb_pkg::*;
#(
    parameter int FILTER_LEN = FILTER_LEN_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pad_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CW = cnt_w(FILTER_LEN);
    localparam logic [CW-1:0] C_LAST = CW'(FILTER_LEN - 1);

    logic [1:0]    sync_q;
    logic          filt_q, filt_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;

    always_comb begin
        filt_d = filt_q;
        cnt_d  = cnt_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (sync_q[1] == filt_q) begin
            cnt_d = '0;
        end else if (cnt_q == C_LAST) begin
            filt_d = sync_q[1];
            cnt_d  = '0;
            rise_d = sync_q[1];
            fall_d = ~sync_q[1];
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= {2{SCCB_IDLE_LEVEL}};
            filt_q <= SCCB_IDLE_LEVEL;
            cnt_q  <= '0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], pad_i};
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign level_o = filt_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/sccb_line_conditioner.sv
// Open-drain drive, filtered read-back, start/stop detection and
// stuck-low watchdog for the two SCCB lines.
module sccb_line_conditioner
    import sccb_pkg::*;
#(
    parameter int FILTER_LEN   = FILTER_LEN_DEF,
    parameter int STUCK_CYCLES = STUCK_CYCLES_DEF
) (
    input logic                    PCLK,
    input logic                    PRESET,
    sccb_line_conditioner_if.slave bus
);

    localparam int SW = cnt_w(STUCK_CYCLES);
    localparam logic [SW-1:0] S_LAST = SW'(STUCK_CYCLES - 1);

    logic [1:0]         pad_oe_q, pad_oe_d;
    logic [1:0]         filt, rise, fall;
    logic [1:0]         low_ext, sat;
    logic [1:0][SW-1:0] scnt_q, scnt_d;
    logic [1:0]         stuck_q, stuck_d;

    // Driving a 1 releases the line; only a driven 0 pulls low.
    assign pad_oe_d = bus.GPIO_OE & ~bus.GPIO_OUT;

    sccb_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_c (
        .clk_i   (PCLK),
        .rst_i   (PRESET),
        .pad_i   (bus.PAD_I[SIO_C_IDX]),
        .level_o (filt[SIO_C_IDX]),
        .rise_o  (rise[SIO_C_IDX]),
        .fall_o  (fall[SIO_C_IDX])
    );

    sccb_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_d (
        .clk_i   (PCLK),
        .rst_i   (PRESET),
        .pad_i   (bus.PAD_I[SIO_D_IDX]),
        .level_o (filt[SIO_D_IDX]),
        .rise_o  (rise[SIO_D_IDX]),
        .fall_o  (fall[SIO_D_IDX])
    );

    assign low_ext = ~filt & ~pad_oe_q;

    always_comb begin
        scnt_d  = scnt_q;
        stuck_d = stuck_q;
        sat     = '0;
        for (int i = 0; i < 2; i++) begin
            sat[i] = low_ext[i] && (scnt_q[i] == S_LAST);
            if (!low_ext[i]) begin
                scnt_d[i] = '0;
            end else if (!sat[i]) begin
                scnt_d[i] = scnt_q[i] + 1'b1;
            end
            // A clear landing on the set cycle wins and restarts the count.
            if (bus.STUCK_CLR) begin
                stuck_d[i] = 1'b0;
                if (sat[i]) begin
                    scnt_d[i] = '0;
                end
            end else if (sat[i]) begin
                stuck_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            pad_oe_q <= '0;
            scnt_q   <= '0;
            stuck_q  <= '0;
        end else begin
            pad_oe_q <= pad_oe_d;
            scnt_q   <= scnt_d;
            stuck_q  <= stuck_d;
        end
    end

    assign bus.PAD_OE    = pad_oe_q;
    assign bus.GPIO_IN   = filt;
    assign bus.EDGE_RISE = rise;
    assign bus.EDGE_FALL = fall;
    assign bus.STUCK_LOW = stuck_q;

    // C high now and not just risen means it was high last cycle too.
    assign bus.START_DET = fall[SIO_D_IDX] & filt[SIO_C_IDX]
                         & ~rise[SIO_C_IDX];
    assign bus.STOP_DET  = rise[SIO_D_IDX] & filt[SIO_C_IDX]
                         & ~rise[SIO_C_IDX];

endmodule

// File: tb/tb_sccb_line_conditioner.sv
// Directed bench for sccb_line_conditioner with an expected-value queue.
module tb_sccb_line_conditioner;

    logic       PCLK = 1'b0;
    logic       PRESET = 1'b1;
    logic [1:0] ext = 2'b11;

    int errors = 0;
    int checks = 0;

    int n_rise, n_fall0, n_fall1, n_start, n_stop, n_start_al, lo0;

    typedef struct {
        string       tag;
        logic [15:0] exp;
    } item_t;

    item_t sb[$];

    localparam logic [15:0] RST_VEC = 16'h0300;

    sccb_line_conditioner_if bus();

    // Open-drain pad: low if the DUT pulls or the outside world pulls.
    assign bus.PAD_I = ext & ~bus.PAD_OE;

    sccb_line_conditioner #(
        .FILTER_LEN   (4),
        .STUCK_CYCLES (100)
    ) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (bus)
    );

    always #5 PCLK = ~PCLK;

    function automatic logic [15:0] obs_all();
        return {4'b0, bus.PAD_OE, bus.GPIO_IN, bus.EDGE_RISE,
                bus.EDGE_FALL, bus.START_DET, bus.STOP_DET,
                bus.STUCK_LOW};
    endfunction

    task automatic expect_val(input string tag, input logic [15:0] e);
        item_t it;
        it.tag = tag;
        it.exp = e;
        sb.push_back(it);
    endtask

    task automatic check(input logic [15:0] obs);
        item_t it;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL sb_empty observed=%0h expected=none", obs);
        end else begin
            it = sb.pop_front();
            assert (obs === it.exp) else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h",
                       it.tag, obs, it.exp);
            end
        end
    endtask

    task automatic clr_mon();
        n_rise = 0; n_fall0 = 0; n_fall1 = 0;
        n_start = 0; n_stop = 0; n_start_al = 0; lo0 = 0;
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge PCLK);
            n_rise  += int'(bus.EDGE_RISE[0]) + int'(bus.EDGE_RISE[1]);
            n_fall0 += int'(bus.EDGE_FALL[0]);
            n_fall1 += int'(bus.EDGE_FALL[1]);
            n_start += int'(bus.START_DET);
            n_stop  += int'(bus.STOP_DET);
            if (bus.START_DET && bus.EDGE_FALL[1]) n_start_al++;
            if (!bus.GPIO_IN[0]) lo0++;
        end
    endtask

    initial begin
        bus.GPIO_OUT  = 2'b00;
        bus.GPIO_OE   = 2'b00;
        bus.STUCK_CLR = 1'b0;
        clr_mon();

        // Reset state
        cyc(3);
        expect_val("reset_state", RST_VEC);
        check(obs_all());
        PRESET = 1'b0;
        cyc(8);
        expect_val("idle_after_reset", RST_VEC);
        check(obs_all());

        // 3-cycle glitch on C is rejected
        clr_mon();
        ext = 2'b10;
        cyc(3);
        ext = 2'b11;
        cyc(12);
        expect_val("glitch3_gpio_low_cycles", 16'd0);
        check(16'(lo0));
        expect_val("glitch3_fall_pulses", 16'd0);
        check(16'(n_fall0));

        // 4-cycle low on C is accepted after 6 edges
        clr_mon();
        ext = 2'b10;
        cyc(4);
        ext = 2'b11;
        cyc(1);
        expect_val("low4_gpio_at5", 16'd1);
        check(16'(bus.GPIO_IN[0]));
        cyc(1);
        expect_val("low4_gpio_at6", 16'd0);
        check(16'(bus.GPIO_IN[0]));
        expect_val("low4_fall_at6", 16'b01);
        check(16'(bus.EDGE_FALL));
        cyc(1);
        expect_val("low4_fall_cleared", 16'b00);
        check(16'(bus.EDGE_FALL));
        cyc(12);
        expect_val("low4_fall_count", 16'd1);
        check(16'(n_fall0));
        expect_val("low4_start_count", 16'd0);
        check(16'(n_start));
        expect_val("low4_gpio_back", 16'b11);
        check(16'(bus.GPIO_IN));

        // Drive path
        bus.GPIO_OE  = 2'b11;
        bus.GPIO_OUT = 2'b00;
        cyc(1);
        expect_val("drive_oe11_out00", 16'b11);
        check(16'(bus.PAD_OE));
        bus.GPIO_OUT = 2'b01;
        cyc(1);
        expect_val("drive_out01", 16'b10);
        check(16'(bus.PAD_OE));
        bus.GPIO_OE = 2'b00;
        cyc(1);
        expect_val("drive_oe00", 16'b00);
        check(16'(bus.PAD_OE));
        cyc(10);
        expect_val("drive_short_pull_filtered", 16'b11);
        check(16'(bus.GPIO_IN));

        // Self read-back on D; watchdog must ignore it
        bus.GPIO_OE = 2'b10;
        cyc(6);
        expect_val("selfrb_gpio_at6", 16'b11);
        check(16'(bus.GPIO_IN));
        cyc(1);
        expect_val("selfrb_gpio_at7", 16'b01);
        check(16'(bus.GPIO_IN));
        cyc(150);
        expect_val("selfrb_no_stuck", 16'b00);
        check(16'(bus.STUCK_LOW));
        bus.GPIO_OE = 2'b00;
        cyc(12);
        expect_val("selfrb_released_no_stuck", 16'b00);
        check(16'(bus.STUCK_LOW));

        // Start / stop
        clr_mon();
        ext = 2'b01;
        cyc(12);
        expect_val("start_count", 16'd1);
        check(16'(n_start));
        expect_val("start_aligned_fall_d", 16'd1);
        check(16'(n_start_al));
        ext = 2'b11;
        cyc(12);
        expect_val("stop_count", 16'd1);
        check(16'(n_stop));
        ext = 2'b00;
        cyc(12);
        expect_val("both_drop_d_fell", 16'd2);
        check(16'(n_fall1));
        expect_val("both_drop_no_start", 16'd1);
        check(16'(n_start));
        ext = 2'b11;
        cyc(12);
        expect_val("both_rise_no_stop", 16'd1);
        check(16'(n_stop));

        // Watchdog on D held low externally
        ext = 2'b01;
        cyc(6);
        expect_val("wd_gpio_fell", 16'b01);
        check(16'(bus.GPIO_IN));
        cyc(99);
        expect_val("wd_not_yet_99", 16'b00);
        check(16'(bus.STUCK_LOW));
        cyc(1);
        expect_val("wd_set_100", 16'b10);
        check(16'(bus.STUCK_LOW));
        ext = 2'b11;
        cyc(12);
        expect_val("wd_sticky_after_rise", 16'b10);
        check(16'(bus.STUCK_LOW));
        bus.STUCK_CLR = 1'b1;
        cyc(1);
        bus.STUCK_CLR = 1'b0;
        expect_val("wd_cleared", 16'b00);
        check(16'(bus.STUCK_LOW));

        // Clear/set collision
        ext = 2'b01;
        cyc(6);
        cyc(99);
        bus.STUCK_CLR = 1'b1;
        cyc(1);
        bus.STUCK_CLR = 1'b0;
        expect_val("coll_clear_wins", 16'b00);
        check(16'(bus.STUCK_LOW));
        cyc(99);
        expect_val("coll_restart_99", 16'b00);
        check(16'(bus.STUCK_LOW));
        cyc(1);
        expect_val("coll_resets_100", 16'b10);
        check(16'(bus.STUCK_LOW));
        ext = 2'b11;
        bus.STUCK_CLR = 1'b1;
        cyc(1);
        bus.STUCK_CLR = 1'b0;
        cyc(10);

        // Asynchronous reset mid-operation
        bus.GPIO_OE  = 2'b01;
        bus.GPIO_OUT = 2'b00;
        ext = 2'b01;
        cyc(30);
        expect_val("pre_reset_gpio", 16'b00);
        check(16'(bus.GPIO_IN));
        PRESET = 1'b1;
        #1;
        expect_val("async_reset_state", RST_VEC);
        check(obs_all());
        bus.GPIO_OE = 2'b00;
        ext = 2'b11;
        cyc(3);
        PRESET = 1'b0;
        clr_mon();
        cyc(10);
        expect_val("no_pulse_after_reset", 16'd0);
        check(16'(n_rise + n_fall0 + n_fall1 + n_start + n_stop));
        expect_val("idle_after_midreset", RST_VEC);
        check(obs_all());

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
